// File: rtl/mem_port_master_if.sv
// Control-unit request/response channel plus memory strobe bus for mem_port_master.
interface mem_port_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_master.sv
// Main-memory port initiator: one single-word load/store in flight at a time,
// with optional rejection of misaligned addresses.
module mem_port_master #(
  parameter int unsigned MEM_LAT     = 1,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_master_if.master   bus,
  output logic [7:0]          err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      state_q;
  logic [2:0]  wait_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [7:0]  err_count_q;
  logic        misaligned;

  assign misaligned = ALIGN_CHECK && (bus.req_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            mem_addr_q  <= bus.req_addr;
            mem_wdata_q <= bus.req_wdata;
            if (misaligned) begin
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
              state_q      <= S_RESP;
            end else if (bus.req_we) begin
              mem_wr_q <= 1'b1;
              state_q  <= S_WR;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= S_RD;
            end
          end
        end
        S_WR: begin
          mem_wr_q     <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          state_q      <= S_RESP;
        end
        S_RD: begin
          mem_rd_q <= 1'b0;
          wait_q   <= LAT_M1;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // Counter reaching zero marks the cycle in which mem_rdata is stable.
          if (wait_q == 3'd0) begin
            resp_rdata_q <= bus.mem_rdata;
            resp_err_q   <= 1'b0;
            state_q      <= S_RESP;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master: a MEM_LAT=1 and a MEM_LAT=3 instance share
// one word-addressed memory model; inputs change and outputs are sampled on negedge.
module tb_mem_port_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_master_if if1 ();
  mem_port_master_if if3 ();
  logic [7:0] err1, err3;

  mem_port_master #(.MEM_LAT(1), .ALIGN_CHECK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .err_count(err1));
  mem_port_master #(.MEM_LAT(3), .ALIGN_CHECK(1'b1)) dut3 (
    .clk(clk), .rst(rst), .bus(if3), .err_count(err3));

  // Shared stimulus, routed to the selected instance.
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;

  assign if1.req_valid  = req_valid & ~sel;
  assign if3.req_valid  = req_valid & sel;
  assign if1.req_we     = req_we;
  assign if3.req_we     = req_we;
  assign if1.req_addr   = req_addr;
  assign if3.req_addr   = req_addr;
  assign if1.req_wdata  = req_wdata;
  assign if3.req_wdata  = req_wdata;
  assign if1.resp_ready = resp_ready;
  assign if3.resp_ready = resp_ready;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_rd, o_mem_wr;
  logic [31:0] o_resp_rdata, o_mem_addr;
  logic [7:0]  o_err;
  assign o_req_ready  = sel ? if3.req_ready  : if1.req_ready;
  assign o_resp_valid = sel ? if3.resp_valid : if1.resp_valid;
  assign o_resp_err   = sel ? if3.resp_err   : if1.resp_err;
  assign o_resp_rdata = sel ? if3.resp_rdata : if1.resp_rdata;
  assign o_mem_rd     = sel ? if3.mem_rd     : if1.mem_rd;
  assign o_mem_wr     = sel ? if3.mem_wr     : if1.mem_wr;
  assign o_mem_addr   = sel ? if3.mem_addr   : if1.mem_addr;
  assign o_err        = sel ? err3           : err1;

  // Memory model: data is valid only for MEM_LAT cycles after the sampling edge's
  // pipeline, otherwise a poison word, so a mistimed capture shows up.
  logic [31:0] mem [0:1023];
  logic [31:0] rd1, p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    if (if1.mem_wr) mem[if1.mem_addr[11:2]] <= if1.mem_wdata;
    rd1  <= if1.mem_rd ? mem[if1.mem_addr[11:2]] : 32'hDEADBEEF;
    p3_0 <= if3.mem_rd ? mem[if3.mem_addr[11:2]] : 32'hDEADBEEF;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign if1.mem_rdata = rd1;
  assign if3.mem_rdata = p3_2;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  // One complete transaction on the selected instance; latency is counted in
  // edges from acceptance until resp_valid is first observed.
  task automatic txn(input vec_t v);
    int lat, rdp, wrp;
    @(negedge clk);
    check({v.name, " req_ready"}, 32'(o_req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; rdp = 0; wrp = 0;
    while (!o_resp_valid && lat < 20) begin
      if (o_mem_rd) rdp++;
      if (o_mem_wr) wrp++;
      if (o_mem_rd || o_mem_wr) check({v.name, " mem_addr"}, o_mem_addr, v.addr);
      if (o_mem_rd && o_mem_wr) check({v.name, " rd_wr_excl"}, 32'd1, 32'd0);
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, " resp_err"}, 32'(o_resp_err), 32'(v.exp_err));
    check({v.name, " resp_rdata"}, o_resp_rdata, v.exp_rdata);
    check({v.name, " rd_pulses"}, 32'(rdp), 32'(v.exp_rd));
    check({v.name, " wr_pulses"}, 32'(wrp), 32'(v.exp_wr));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({v.name, " resp_valid_drop"}, 32'(o_resp_valid), 32'd0);
  endtask

  vec_t vecs [9];

  initial begin
    int n;
    bit seen;
    vecs[0] = '{"st_2116",  1'b1, 32'd2116, 32'h0000_0001, 32'h0,          1'b0, 1, 0, 1};
    vecs[1] = '{"ld_2116",  1'b0, 32'd2116, 32'h0,         32'h0000_0001,  1'b0, 2, 1, 0};
    vecs[2] = '{"ld_2049",  1'b0, 32'd2049, 32'h0,         32'h0,          1'b1, 0, 0, 0};
    vecs[3] = '{"st_100",   1'b1, 32'd100,  32'hA5A5_0F0F, 32'h0,          1'b0, 1, 0, 1};
    vecs[4] = '{"st_2050",  1'b1, 32'd2050, 32'h1234_5678, 32'h0,          1'b1, 0, 0, 0};
    vecs[5] = '{"ld_100",   1'b0, 32'd100,  32'h0,         32'hA5A5_0F0F,  1'b0, 2, 1, 0};
    vecs[6] = '{"st_2048",  1'b1, 32'd2048, 32'hC200_2844, 32'h0,          1'b0, 1, 0, 1};
    vecs[7] = '{"st_2052",  1'b1, 32'd2052, 32'h8280_4002, 32'h0,          1'b0, 1, 0, 1};
    vecs[8] = '{"ld_2052",  1'b0, 32'd2052, 32'h0,         32'h8280_4002,  1'b0, 2, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sel = (d == 1);
      #1;
      check("rst req_ready",  32'(o_req_ready), 32'd1);
      check("rst resp_valid", 32'(o_resp_valid), 32'd0);
      check("rst strobes",    {30'd0, o_mem_rd, o_mem_wr}, 32'd0);
      check("rst mem_addr",   o_mem_addr, 32'd0);
      check("rst resp",       {o_resp_err, o_resp_rdata[30:0]}, 32'd0);
      check("rst err_count",  32'(o_err), 32'd0);
    end
    sel = 1'b0;
    check("rst mem_wdata", if1.mem_wdata, 32'd0);

    // Table-driven transactions on the MEM_LAT=1 instance
    for (int i = 0; i < 9; i++) txn(vecs[i]);
    @(negedge clk);
    check("table err_count", 32'(o_err), 32'd2);

    // Response backpressure with a competing request held on req_valid
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd2048; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!o_resp_valid && n < 20) begin @(negedge clk); n++; end
    check("bp latency", 32'(n), 32'd2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd300; req_wdata = 32'h33;
    for (int k = 0; k < 5; k++) begin
      check("bp resp_valid", 32'(o_resp_valid), 32'd1);
      check("bp resp_rdata", o_resp_rdata, 32'hC200_2844);
      check("bp req_ready",  32'(o_req_ready), 32'd0);
      check("bp held_addr",  o_mem_addr, 32'd2048);
      check("bp no_strobe",  {30'd0, o_mem_rd, o_mem_wr}, 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp idle req_ready",  32'(o_req_ready), 32'd1);
    check("bp idle resp_valid", 32'(o_resp_valid), 32'd0);
    check("bp not_yet_addr",    o_mem_addr, 32'd2048);
    check("bp not_yet_wr",      32'(o_mem_wr), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp accept_wr",   32'(o_mem_wr), 32'd1);
    check("bp accept_addr", o_mem_addr, 32'd300);
    @(negedge clk);
    check("bp st resp_valid", 32'(o_resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // MEM_LAT=3 instance
    sel = 1'b1;
    txn('{"lat3_ld_2052", 1'b0, 32'd2052, 32'h0, 32'h8280_4002, 1'b0, 4, 1, 0});

    // Reset while the MEM_LAT=3 instance is in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd2052;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort in_rd", 32'(o_mem_rd), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort req_ready",  32'(o_req_ready), 32'd1);
    check("abort resp_valid", 32'(o_resp_valid), 32'd0);
    check("abort strobes",    {30'd0, o_mem_rd, o_mem_wr}, 32'd0);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (o_resp_valid) seen = 1'b1; end
    check("abort no_resp", 32'(seen), 32'd0);

    // err_count saturation on the MEM_LAT=1 instance
    sel = 1'b0;
    seen = 1'b0;
    resp_ready = 1'b1;
    req_we = 1'b0; req_addr = 32'd2049;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      if (o_mem_rd || o_mem_wr) seen = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (o_mem_rd || o_mem_wr) seen = 1'b1;
      if (i == 0)   check("sat first",   32'(o_err), 32'd1);
      if (i == 254) check("sat at_255",  32'(o_err), 32'd255);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    check("sat final", 32'(o_err), 32'd255);
    check("sat no_strobe", 32'(seen), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("sat rst_clear", 32'(o_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
